// File: rtl/filter_sink_pkg.sv
// Shared types and sizing helpers for the filter_sink slice.
// Entry layout is {parity, data}; pointers carry one extra wrap bit.
package filter_sink_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF  = 8;

  typedef struct packed {
    logic                      parity;
    logic [DATA_WIDTH_DEF-1:0] data;
  } entry_t;

  // Index bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sink_fifo_core.sv
// Storage, read/write pointers and full/empty/occupancy decode for filter_sink.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module sink_fifo_core
  import filter_sink_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_WIDTH_DEF + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
    end
  end

  // Head is read straight from storage: no bypass from wdata.
  assign rdata = mem[rptr[AW-1:0]];
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;

endmodule

// File: rtl/filter_sink.sv
// Converts the non-stallable filter output stream into a ready/valid stream,
// buffering in a small FIFO and reporting drops, occupancy and accepted beats.
module filter_sink
  import filter_sink_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   io_x_data,
  input  logic                    io_x_valid,
  input  logic                    io_x_parity,
  output logic [DATA_WIDTH-1:0]   io_y_data,
  output logic                    io_y_parity,
  output logic                    io_y_valid,
  input  logic                    io_y_ready,
  output logic [$clog2(DEPTH):0]  io_count,
  output logic                    io_overflow,
  output logic [CNT_WIDTH-1:0]    io_drops,
  output logic [CNT_WIDTH-1:0]    io_beats
);

  localparam int EW = DATA_WIDTH + 1;

  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [EW-1:0] head;

  // Handshake: io_y transfers when io_y_valid & io_y_ready on a rising edge;
  // io_y_valid depends only on registered state and never falls without a pop.
  // Upstream has no ready: a beat arriving while full and not popping is lost.
  assign io_y_valid = ~empty;
  assign pop        = io_y_valid & io_y_ready;
  assign push       = io_x_valid & (~full | pop);
  assign drop       = io_x_valid & full & ~pop;

  sink_fifo_core #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({io_x_parity, io_x_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (io_count)
  );

  assign io_y_parity = head[EW-1];
  assign io_y_data   = head[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_overflow <= 1'b0;
      io_drops    <= '0;
      io_beats    <= '0;
    end else begin
      if (drop) begin
        io_overflow <= 1'b1;
        if (io_drops != '1) io_drops <= io_drops + CNT_WIDTH'(1);
      end
      if (push) io_beats <= io_beats + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/filter_sink.md
# filter_sink

Downstream consumer of the filter chain: captures the free-running, non-stallable {data, valid, parity} stream leaving the last filter stage and converts it into a ready/valid stream with backpressure. The block buffers beats in a small FIFO, so a slow consumer does not lose data while the FIFO has space. It reports drops, occupancy and the running beat count. It sits between the filter block's output and any stalling consumer.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DATA_WIDTH, 16, width of the data field.
- CNT_WIDTH, 8, width of the drop and beat counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- io_x_data  in  DATA_WIDTH  upstream data.
- io_x_valid  in  1  upstream beat qualifier; the block cannot stall upstream.
- io_x_parity  in  1  upstream parity/carry bit; stored alongside data.
- io_y_data  out  DATA_WIDTH  head entry data.
- io_y_parity  out  1  head entry parity.
- io_y_valid  out  1  FIFO not empty.
- io_y_ready  in  1  consumer accepts the head entry.
- io_count  out  log2(DEPTH)+1  current occupancy.
- io_overflow  out  1  sticky; a beat has been dropped.
- io_drops  out  CNT_WIDTH  number of dropped beats; saturates at all-ones.
- io_beats  out  CNT_WIDTH  number of beats accepted into the FIFO; wraps modulo 2^CNT_WIDTH.

## Operation
- Entry storage: {parity, data}, DATA_WIDTH+1 bits wide. The parity bit is passed through unmodified.
- pop = io_y_valid & io_y_ready.
- push = io_x_valid & (!full | pop). A beat arriving when full is accepted if a pop occurs in the same cycle.
- drop = io_x_valid & full & !pop.
  - On drop: no write occurs.
  - io_overflow is set to 1 and stays at 1 until reset.
  - io_drops increments and saturates at all-ones.
- io_beats increments on every push.
- Pointers:
  - Write and read pointers are log2(DEPTH)+1 bits wide, so full and empty are distinguished by the extra MSB.
  - Pointers wrap naturally.
- Full and empty:
  - full when the pointers are equal in the low bits and differ in the MSB.
  - empty when the pointers are fully equal.
- Occupancy: io_count = wptr - rptr, ranging 0..DEPTH.
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
- No bypass: a beat pushed into an empty FIFO is not visible on io_y in the same cycle.
- io_y_data and io_y_parity are valid only when io_y_valid=1. When io_y_valid=0 they show the stale storage contents and must not be relied on.
- Consumer rule: io_y_valid never drops without a pop.

## Timing
- Reset values: io_y_valid=0, io_count=0, io_overflow=0, io_drops=0, io_beats=0, pointers=0.
  - io_y_data and io_y_parity are 0 after reset; storage is cleared.
- Reset mid-operation flushes all entries. Outputs reach their reset values without waiting for a clock edge.
- Latency: a beat sampled on edge N appears on io_y from just after edge N, when the FIFO was empty.
- io_y_valid, io_count, io_overflow, io_drops and io_beats are registered or decoded from registers only. io_y_ready has no combinational path to io_y_valid.
- One push and one pop are allowed per cycle.
- Sustained throughput is 1 beat/cycle when io_y_ready is held high.

## Structure
- Package filter_sink_pkg holds:
  - DATA_WIDTH and CNT_WIDTH defaults.
  - Entry typedef {parity, data}.
  - Pointer-width function log2(DEPTH)+1.
- Sub-module sink_fifo_core holds the storage, the pointers and the full/empty/count logic, parameterized by DEPTH and entry width.
- The top level holds the push/pop/drop decode and the overflow, drop and beat counters.

## Test plan
- Reset, then single beat: drive io_x_data=0x1234, parity=1, valid for 1 cycle, with io_y_ready=0.
  - Next cycle: io_y_valid=1, data=0x1234, parity=1, io_count=1.
  - Then raise ready: io_y_valid=0 after 1 edge, io_beats=1.
- Fill and overflow: io_y_ready=0, 6 consecutive beats 0x0001..0x0006 with DEPTH=4.
  - io_count=4 and io_overflow=1.
  - io_drops=2 and io_beats=4.
  - Drain order is 0x0001..0x0004.
- Full with simultaneous pop: FIFO full, io_y_ready=1, new beat 0x00AA.
  - No drop and io_count stays 4.
  - 0x00AA emerges 4 pops later.
- Streaming: ready held high and 100 back-to-back beats.
  - Output is in order with 1-cycle latency.
  - io_count never exceeds 1, io_beats=100 (mod 256), no overflow.
- Drop saturation: 300 drops with CNT_WIDTH=8.
  - io_drops=255 and holds.
  - io_overflow=1.
- Async reset mid-stream: assert reset between edges with 3 entries queued.
  - io_y_valid, io_count and all counters go to 0 before the next edge.
  - After deassert, normal operation resumes.
